// File: rtl/bitwise_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_alu_arbiter
// Description : Round-robin sharing of one bitwise logic unit among NUM_REQ
//               requesters, with a single registered valid/ready result stage.
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_x,
    input  logic [NUM_REQ*W-1:0] req_y,
    input  logic [NUM_REQ*3-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_result,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_NAND = 3'b001;
    localparam logic [2:0] c_OP_OR   = 3'b010;
    localparam logic [2:0] c_OP_NOR  = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_XNOR = 3'b101;

    logic               r_valid;
    logic [W-1:0]       r_result;
    logic [IDW-1:0]     r_id;
    logic               r_err;
    logic [IDW-1:0]     r_ptr;

    logic               w_take;
    logic               w_found;
    logic [IDW-1:0]     w_gnt;
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [W-1:0]       w_x;
    logic [W-1:0]       w_y;
    logic [2:0]         w_op;
    logic [W-1:0]       w_res;
    logic               w_err;

    // The output stage can accept when empty or when it drains this cycle.
    assign w_take = !r_valid || rsp_ready;

    always_comb begin : arbiter
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin : operand_mux
        w_x  = '0;
        w_y  = '0;
        w_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                w_x  = req_x[i*W +: W];
                w_y  = req_y[i*W +: W];
                w_op = req_op[i*3 +: 3];
            end
        end
    end

    always_comb begin : logic_unit
        w_res = '0;
        w_err = 1'b0;
        case (w_op)
            c_OP_AND:  w_res = w_x & w_y;
            c_OP_NAND: w_res = ~(w_x & w_y);
            c_OP_OR:   w_res = w_x | w_y;
            c_OP_NOR:  w_res = ~(w_x | w_y);
            c_OP_XOR:  w_res = w_x ^ w_y;
            c_OP_XNOR: w_res = w_x ~^ w_y;
            default:   w_err = 1'b1;
        endcase
    end

    assign w_ptr_nxt = (w_gnt == IDW'(NUM_REQ-1)) ? '0 : w_gnt + IDW'(1);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && w_take && w_found && (w_gnt == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_id     <= '0;
            r_err    <= 1'b0;
            r_ptr    <= '0;
        end else if (w_take) begin
            if (w_found) begin
                r_valid  <= 1'b1;
                r_result <= w_res;
                r_id     <= w_gnt;
                r_err    <= w_err;
                r_ptr    <= w_ptr_nxt;
            end else if (rsp_ready) begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign rsp_valid  = r_valid;
    assign rsp_result = r_result;
    assign rsp_id     = r_id;
    assign rsp_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_alu_arbiter
// Description : Directed, table-driven bench for bitwise_alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [11:0] req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_result;
    logic [1:0]  rsp_id;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    bitwise_alu_arbiter #(.NUM_REQ(4), .W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] x;
        logic [31:0] y;
        logic [11:0] op;
        logic        rr;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [7:0]  e_res;
        logic [1:0]  e_id;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] v, logic [31:0] x, logic [31:0] y,
                                logic [11:0] op, logic rr, logic [3:0] e_ready,
                                logic e_valid, logic [7:0] e_res, logic [1:0] e_id,
                                logic e_err);
        vec_t t;
        t.v = v; t.x = x; t.y = y; t.op = op; t.rr = rr;
        t.e_ready = e_ready; t.e_valid = e_valid; t.e_res = e_res;
        t.e_id = e_id; t.e_err = e_err;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational grant, then the
    // registered result just after the rising edge.
    task automatic step(input vec_t t, input string tag);
        req_valid = t.v;
        req_x     = t.x;
        req_y     = t.y;
        req_op    = t.op;
        rsp_ready = t.rr;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(t.e_ready));
        @(posedge clk);
        #1;
        chk({tag, "_valid"},  32'(rsp_valid),  32'(t.e_valid));
        chk({tag, "_result"}, 32'(rsp_result), 32'(t.e_res));
        chk({tag, "_id"},     32'(rsp_id),     32'(t.e_id));
        chk({tag, "_err"},    32'(rsp_err),    32'(t.e_err));
    endtask

    // Data sets: X1/Y1/O1 give req0 OR->FF, req1 XOR->F0, req2 NAND->FF, req3 AND->30.
    localparam logic [31:0] X1 = 32'hF0FF0FAA;
    localparam logic [31:0] Y1 = 32'h3C00FF55;
    localparam logic [11:0] O1 = 12'b000_001_100_010;
    // req0 AND F0&3C -> 30, req1 NOR ~(AA|0F) -> 50.
    localparam logic [31:0] X2 = 32'h0000AAF0;
    localparam logic [31:0] Y2 = 32'h00000F3C;
    localparam logic [11:0] O2 = 12'b000_000_011_000;

    initial begin
        logic [7:0] opc_exp [8];
        opc_exp[0] = 8'h4A; opc_exp[1] = 8'hB5; opc_exp[2] = 8'hDF; opc_exp[3] = 8'h20;
        opc_exp[4] = 8'h95; opc_exp[5] = 8'h6A; opc_exp[6] = 8'h00; opc_exp[7] = 8'h00;

        // First op after reset, all valid: requester 0 wins.
        vecs.push_back(mk(4'b1111, X1, Y1, O1, 1'b1, 4'b0001, 1'b1, 8'hFF, 2'd0, 1'b0));
        // Op coverage on requester 2 alone.
        for (int i = 0; i < 8; i++) begin
            logic [11:0] opw;
            opw = 12'(i) << 6;
            vecs.push_back(mk(4'b0100, 32'h00CA0000, 32'h005F0000, opw, 1'b1, 4'b0100,
                              1'b1, opc_exp[i], 2'd2, (i >= 6)));
        end
        // Requester 3 alone moves the pointer back to 0.
        vecs.push_back(mk(4'b1000, X1, Y1, O1, 1'b1, 4'b1000, 1'b1, 8'h30, 2'd3, 1'b0));
        // Round robin, two full rotations, no idle cycles.
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(4'b1111, X1, Y1, O1, 1'b1, 4'b0001, 1'b1, 8'hFF, 2'd0, 1'b0));
            vecs.push_back(mk(4'b1111, X1, Y1, O1, 1'b1, 4'b0010, 1'b1, 8'hF0, 2'd1, 1'b0));
            vecs.push_back(mk(4'b1111, X1, Y1, O1, 1'b1, 4'b0100, 1'b1, 8'hFF, 2'd2, 1'b0));
            vecs.push_back(mk(4'b1111, X1, Y1, O1, 1'b1, 4'b1000, 1'b1, 8'h30, 2'd3, 1'b0));
        end
        // Skip and wrap: only 1 and 3 valid.
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(4'b1010, X1, Y1, O1, 1'b1, 4'b0010, 1'b1, 8'hF0, 2'd1, 1'b0));
            vecs.push_back(mk(4'b1010, X1, Y1, O1, 1'b1, 4'b1000, 1'b1, 8'h30, 2'd3, 1'b0));
        end
        // Backpressure: result from 0 held three cycles, then 1 accepted on drain.
        vecs.push_back(mk(4'b0001, X2, Y2, O2, 1'b1, 4'b0001, 1'b1, 8'h30, 2'd0, 1'b0));
        for (int s = 0; s < 3; s++) begin
            vecs.push_back(mk(4'b0010, X2, Y2, O2, 1'b0, 4'b0000, 1'b1, 8'h30, 2'd0, 1'b0));
        end
        vecs.push_back(mk(4'b0010, X2, Y2, O2, 1'b1, 4'b0010, 1'b1, 8'h50, 2'd1, 1'b0));
        // Idle drain: valid drops, data holds.
        vecs.push_back(mk(4'b0000, X2, Y2, O2, 1'b1, 4'b0000, 1'b0, 8'h50, 2'd1, 1'b0));

        // Reset with everything requesting.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_x     = X1;
        req_y     = Y1;
        req_op    = O1;
        rsp_ready = 1'b1;
        #1;
        chk("rst_ready",  32'(req_ready),  32'h0);
        chk("rst_valid",  32'(rsp_valid),  32'h0);
        chk("rst_result", 32'(rsp_result), 32'h0);
        chk("rst_id",     32'(rsp_id),     32'h0);
        chk("rst_err",    32'(rsp_err),    32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_ready", 32'(req_ready), 32'h0);
        chk("rst_hold_valid", 32'(rsp_valid), 32'h0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while a result is stalled (pointer is 2 here).
        step(mk(4'b1000, X1, Y1, O1, 1'b1, 4'b1000, 1'b1, 8'h30, 2'd3, 1'b0), "ms_load");
        step(mk(4'b1000, X1, Y1, O1, 1'b0, 4'b0000, 1'b1, 8'h30, 2'd3, 1'b0), "ms_stall");
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        chk("ms_rst_valid",  32'(rsp_valid),  32'h0);
        chk("ms_rst_ready",  32'(req_ready),  32'h0);
        chk("ms_rst_result", 32'(rsp_result), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(mk(4'b1111, X1, Y1, O1, 1'b1, 4'b0001, 1'b1, 8'hFF, 2'd0, 1'b0), "ms_after");
        step(mk(4'b0000, X1, Y1, O1, 1'b1, 4'b0000, 1'b0, 8'hFF, 2'd0, 1'b0), "ms_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitwise_alu_arbiter.md
# bitwise_alu_arbiter

Shares one 8-bit bitwise logic unit (AND/NAND/OR/NOR/XOR/XNOR) between `NUM_REQ` independent requesters. Each cycle it selects at most one valid request by round-robin, evaluates the operation, and holds the result in a single registered output stage with valid/ready backpressure. It sits between the requesting datapath blocks and the consumer of logic results, and replaces per-requester copies of the logic unit.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `W`, 8: operand/result width.
- `IDW`, `$clog2(NUM_REQ)`: requester-index width (localparam).

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  bit i: requester i presents an operation.
- `req_ready`  out  NUM_REQ  bit i: requester i's operation accepted this cycle.
- `req_x`  in  NUM_REQ*W  operand x; requester i at bits [i*W +: W].
- `req_y`  in  NUM_REQ*W  operand y, same packing.
- `req_op`  in  NUM_REQ*3  op code; requester i at bits [i*3 +: 3].
- `rsp_valid`  out  1  result register holds an undelivered result.
- `rsp_ready`  in  1  consumer accepts the result this cycle.
- `rsp_result`  out  W  registered result.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `rsp_err`  out  1  op code was illegal (110 or 111).

## Operation
- Op codes: 000 AND, 001 NAND (~(x&y)), 010 OR, 011 NOR (~(x|y)), 100 XOR, 101 XNOR (x~^y). 110/111 are illegal: result 0, `rsp_err`=1. For legal codes `rsp_err`=0.
- Accept condition: `take = !rsp_valid || rsp_ready`. No request is accepted while the output register is full and stalled.
- Arbitration: round-robin pointer `ptr` (IDW bits). Search order is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1, modulo NUM_REQ. The first requester with `req_valid` high is the winner `g`.
- `req_ready[g] = take && any(req_valid)`. All other `req_ready` bits are 0. At most one bit is high per cycle. `req_ready` depends combinationally on `req_valid` and on `rsp_ready`.
- On a cycle where a request is accepted:
  - `rsp_result` ← op(x_g, y_g).
  - `rsp_id` ← g; `rsp_err` ← illegal(op_g).
  - `rsp_valid` ← 1.
  - `ptr` ← (g+1) mod NUM_REQ.
- If `take` is true and no request is valid: `rsp_valid` ← 0 if `rsp_ready` is high, otherwise it holds. `ptr` holds.
- If `rsp_valid` is high and `rsp_ready` is low: `rsp_result`, `rsp_id`, `rsp_err`, `rsp_valid` and `ptr` all hold. Requesters see all `req_ready` low.
- A requester must hold `req_x`, `req_y` and `req_op` stable while its `req_valid` is high and `req_ready` is low. The block does not check this.
- Illegal ops still consume an arbitration slot and advance `ptr`.

## Timing
- Reset (async assert, sync deassert by the system):
  - `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0, `rsp_err`=0, `ptr`=0.
  - `req_ready` is all-zero while `rst_n` is low.
- Latency: a request accepted at edge N gives `rsp_valid`=1 with its result right after edge N. It is delivered at the first edge ≥N+1 where `rsp_ready`=1.
- Throughput: one op per cycle while `rsp_ready` stays high. Back-to-back accept-and-drain in the same cycle is mandatory (no bubble).
- Fairness: with all NUM_REQ requesters continuously valid and `rsp_ready`=1, grants rotate 0,1,…,NUM_REQ-1,0,…. Any valid requester is granted within NUM_REQ accept cycles.
- Reset mid-operation: a pending result is discarded, with no partial delivery. The first grant after reset goes to the lowest-index valid requester.
- Pointer wrap: after granting NUM_REQ-1, `ptr`=0.

## Test plan
- Reset: hold `rst_n`=0 with all `req_valid`=1 → `req_ready`=0000 and `rsp_valid`=0. After release, the first accepted op is from requester 0 and `rsp_id`=0.
- Op coverage: requester 2 alone, x=8'hCA, y=8'h5F, op 000..111 in turn, `rsp_ready`=1 → results in order:
  - 4A, B5, DF, 20, 95, 6A, 00 (err=1), 00 (err=1).
  - One result per cycle, `rsp_id`=2 throughout.
- Round-robin: all 4 requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,1, with no idle cycles.
- Skip and wrap: only requesters 1 and 3 valid → `rsp_id` sequence 1,3,1,3. Requesters 0 and 2 never see `req_ready`.
- Backpressure: requester 0 sends AND 8'hF0 & 8'h3C, then `rsp_ready`=0 for 3 cycles while requester 1 is valid →
  - `rsp_result`=8'h30 and `rsp_id`=0 hold for 3 cycles.
  - `req_ready`=0000 during the stall.
  - On the cycle `rsp_ready` rises, requester 1 is accepted in the same cycle.
- Reset mid-stall: assert `rst_n`=0 while `rsp_valid`=1 and stalled → `rsp_valid` drops immediately. After release, `ptr`=0 and the stale result never appears.
